// File: rtl/ddr_arbit_pkg.sv
// ddr_arbit_pkg: shared state encoding and constants for the DDR channel arbiter.
// No ports. Optional read slot is enabled by defining DDR_ARBIT_RD_EN.
package ddr_arbit_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_DONE,
        S_RD_CMD,
        S_RD_DATA
    } state_t;
    localparam logic [3:0] IDLE_ID = 4'hF;
    localparam int MAX_CH = 8;
endpackage

// File: rtl/ddr_arbit_nch_rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after i_ptr.
// Ports:
//   i_req   in  SLOTS  request vector
//   i_ptr   in  4      start index, must be below SLOTS
//   o_idx   out 4      winning index (0 when nothing requests)
//   o_valid out 1      any request present
module rr_pick #(
    parameter int SLOTS = 4
) (
    input  logic [SLOTS-1:0] i_req,
    input  logic [3:0]       i_ptr,
    output logic [3:0]       o_idx,
    output logic             o_valid
);
    logic [2*SLOTS-1:0] w_dbl;
    logic [SLOTS-1:0]   w_rot;
    logic [4:0]         w_sum;

    // Rotating a doubled copy puts the pointer slot at bit 0.
    assign w_dbl   = {i_req, i_req};
    assign w_rot   = SLOTS'(w_dbl >> i_ptr);
    assign o_valid = |i_req;

    always_comb begin
        o_idx = '0;
        w_sum = '0;
        // Walk downward so the lowest rotated offset wins.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, i_ptr} + 5'(i);
                o_idx = 4'((w_sum >= 5'(SLOTS)) ? w_sum - 5'(SLOTS) : w_sum);
            end
        end
    end
endmodule

// File: rtl/ddr_arbit_nch.sv
// ddr_arbit_nch: round-robin arbiter sharing one DDR command/data port among NUM_CH writers.
// Ports:
//   ddr_clk, rst                     clock, synchronous active-high reset
//   m_wr_req/addr/len/data           packed per-channel write requests (channel 0 in LSBs)
//   m_ddr_wrdy/wdata_req/wdone       per-channel accept, data-pop and burst-done strobes
//   wr_cmd_en/addr/len, wr_ctrl_data write command and data to the controller
//   wr_cmd_ready/done, wr_data_re    controller handshakes
//   grant_id                         current owner, 4'hF when idle
// Macro DDR_ARBIT_RD_EN adds a read requester (m1_rd_*, rd_cmd_*, read_data, read_en)
// as slot NUM_CH of the rotation.
module ddr_arbit_nch
    import ddr_arbit_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 32,
    parameter int DATA_W = 256
) (
    input  logic                       ddr_clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          m_wr_req,
    input  logic [NUM_CH*ADDR_W-1:0]   m_wr_addr,
    input  logic [NUM_CH*LEN_W-1:0]    m_wr_len,
    input  logic [NUM_CH*DATA_W-1:0]   m_wr_data,
    output logic [NUM_CH-1:0]          m_ddr_wrdy,
    output logic [NUM_CH-1:0]          m_ddr_wdata_req,
    output logic [NUM_CH-1:0]          m_ddr_wdone,
    output logic                       wr_cmd_en,
    output logic [ADDR_W-1:0]          wr_cmd_addr,
    output logic [31:0]                wr_cmd_len,
    input  logic                       wr_cmd_ready,
    input  logic                       wr_cmd_done,
    input  logic                       wr_data_re,
    output logic [DATA_W-1:0]          wr_ctrl_data,
`ifdef DDR_ARBIT_RD_EN
    input  logic                       m1_rd_req,
    input  logic [ADDR_W-1:0]          m1_rd_addr,
    input  logic [LEN_W-1:0]           m1_rd_len,
    output logic [DATA_W-1:0]          m1_rd_data,
    output logic                       m1_rd_ddr_rrdy,
    output logic                       m1_rd_ddr_rdata_en,
    output logic                       m1_rd_ddr_rdone,
    output logic                       rd_cmd_en,
    output logic [ADDR_W-1:0]          rd_cmd_addr,
    output logic [31:0]                rd_cmd_len,
    input  logic [DATA_W-1:0]          read_data,
    input  logic                       rd_cmd_ready,
    input  logic                       rd_cmd_done,
    output logic                       read_en,
`endif
    output logic [3:0]                 grant_id
);
`ifdef DDR_ARBIT_RD_EN
    localparam int SLOTS = NUM_CH + 1;
`else
    localparam int SLOTS = NUM_CH;
`endif

    state_t              r_state, w_next, w_cmd_state;
    logic [3:0]          r_grant, r_ptr, w_pick_idx, w_ptr_inc;
    logic                w_pick_valid, r_zero, w_sel_zero;
    logic [SLOTS-1:0]    w_req;
    logic [ADDR_W-1:0]   r_addr, w_sel_addr;
    logic [LEN_W-1:0]    r_len, w_sel_len;
    logic [DATA_W-1:0]   w_wdata;
    logic [NUM_CH-1:0]   w_oh;

`ifdef DDR_ARBIT_RD_EN
    assign w_req       = {m1_rd_req, m_wr_req};
    assign w_cmd_state = (w_pick_idx == 4'(NUM_CH)) ? S_RD_CMD : S_WR_CMD;
`else
    assign w_req       = m_wr_req;
    assign w_cmd_state = S_WR_CMD;
`endif

    rr_pick #(.SLOTS(SLOTS)) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_wdata    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_pick_idx == 4'(c)) begin
                w_sel_addr = m_wr_addr[c*ADDR_W +: ADDR_W];
                w_sel_len  = m_wr_len[c*LEN_W +: LEN_W];
            end
            if (r_grant == 4'(c))
                w_wdata = m_wr_data[c*DATA_W +: DATA_W];
        end
`ifdef DDR_ARBIT_RD_EN
        if (w_pick_idx == 4'(NUM_CH)) begin
            w_sel_addr = m1_rd_addr;
            w_sel_len  = m1_rd_len;
        end
`endif
    end

    assign w_sel_zero = (w_sel_len == '0);
    // The read slot index shifts out of the NUM_CH-wide one-hot, so write strobes stay quiet.
    assign w_oh       = NUM_CH'(1) << r_grant;
    assign w_ptr_inc  = (r_grant == 4'(SLOTS - 1)) ? 4'd0 : r_grant + 4'd1;

    // State and request latches. The pointer advances while in DONE, which always precedes
    // the next arbitration, so zero-length and normal bursts share one update path.
    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= IDLE_ID;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_pick_valid) begin
                r_grant <= w_pick_idx;
                r_addr  <= w_sel_addr;
                r_len   <= w_sel_len;
                r_zero  <= w_sel_zero;
            end
            if (r_state == S_DONE) begin
                r_ptr   <= w_ptr_inc;
                r_grant <= IDLE_ID;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_pick_valid ? (w_sel_zero ? S_DONE : w_cmd_state) : S_IDLE;
            S_WR_CMD:  w_next = wr_cmd_ready ? S_WR_DATA : S_WR_CMD;
            S_WR_DATA: w_next = wr_cmd_done ? S_DONE : S_WR_DATA;
`ifdef DDR_ARBIT_RD_EN
            S_RD_CMD:  w_next = rd_cmd_ready ? S_RD_DATA : S_RD_CMD;
            S_RD_DATA: w_next = rd_cmd_done ? S_DONE : S_RD_DATA;
`endif
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        grant_id        = (r_state == S_IDLE) ? IDLE_ID : r_grant;
        wr_cmd_en       = (r_state == S_WR_CMD);
        wr_cmd_addr     = wr_cmd_en ? r_addr : '0;
        wr_cmd_len      = wr_cmd_en ? 32'(r_len) : '0;
        m_ddr_wrdy      = (wr_cmd_en && wr_cmd_ready) ? w_oh : '0;
        m_ddr_wdata_req = (r_state == S_WR_DATA && wr_data_re) ? w_oh : '0;
        wr_ctrl_data    = (r_state == S_WR_DATA) ? w_wdata : '0;
        m_ddr_wdone     = ((r_state == S_WR_DATA && wr_cmd_done) ||
                           (r_state == S_DONE && r_zero)) ? w_oh : '0;
`ifdef DDR_ARBIT_RD_EN
        rd_cmd_en          = (r_state == S_RD_CMD);
        rd_cmd_addr        = rd_cmd_en ? r_addr : '0;
        rd_cmd_len         = rd_cmd_en ? 32'(r_len) : '0;
        m1_rd_ddr_rrdy     = rd_cmd_en && rd_cmd_ready;
        m1_rd_ddr_rdata_en = (r_state == S_RD_DATA);
        read_en            = m1_rd_ddr_rdata_en;
        m1_rd_data         = m1_rd_ddr_rdata_en ? read_data : '0;
        m1_rd_ddr_rdone    = (m1_rd_ddr_rdata_en && rd_cmd_done) ||
                             (r_state == S_DONE && r_zero && r_grant == 4'(NUM_CH));
`endif
    end
endmodule

// File: tb/tb_ddr_arbit_nch.sv
// tb_ddr_arbit_nch: directed bench with a cycle model of the arbiter's bus rules.
module tb_ddr_arbit_nch;
    localparam int NCH = 4, AW = 28, LW = 32, DW = 256;
`ifdef DDR_ARBIT_RD_EN
    localparam int SL = NCH + 1;
`else
    localparam int SL = NCH;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH*AW-1:0] addr;
    logic [NCH*LW-1:0] len;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    wrdy, wdreq, wdone;
    logic              cmd_en, any_en;
    logic [AW-1:0]     cmd_addr;
    logic [31:0]       cmd_len;
    logic              cmd_ready = 1'b0, cmd_done = 1'b0, data_re = 1'b0;
    logic [DW-1:0]     ctrl_data;
    logic [3:0]        gid;
`ifdef DDR_ARBIT_RD_EN
    logic              rd_req_i = 1'b0;
    logic [AW-1:0]     rd_addr_i = 28'h0BEEF00;
    logic [LW-1:0]     rd_len_i = 32'd8;
    logic [DW-1:0]     rd_data_o, rcmd_data_unused;
    logic              rrdy_o, rdata_en_o, rdone_o, rcmd_en, read_en_o;
    logic [AW-1:0]     rcmd_addr;
    logic [31:0]       rcmd_len;
    logic [DW-1:0]     read_data_i = {32{8'hA5}};
    logic              rcmd_ready = 1'b0, rcmd_done = 1'b0;
    assign any_en = cmd_en | rcmd_en;
`else
    assign any_en = cmd_en;
`endif

    ddr_arbit_nch dut (
        .ddr_clk(clk), .rst(rst),
        .m_wr_req(req), .m_wr_addr(addr), .m_wr_len(len), .m_wr_data(data),
        .m_ddr_wrdy(wrdy), .m_ddr_wdata_req(wdreq), .m_ddr_wdone(wdone),
        .wr_cmd_en(cmd_en), .wr_cmd_addr(cmd_addr), .wr_cmd_len(cmd_len),
        .wr_cmd_ready(cmd_ready), .wr_cmd_done(cmd_done), .wr_data_re(data_re),
        .wr_ctrl_data(ctrl_data),
`ifdef DDR_ARBIT_RD_EN
        .m1_rd_req(rd_req_i), .m1_rd_addr(rd_addr_i), .m1_rd_len(rd_len_i),
        .m1_rd_data(rd_data_o), .m1_rd_ddr_rrdy(rrdy_o), .m1_rd_ddr_rdata_en(rdata_en_o),
        .m1_rd_ddr_rdone(rdone_o), .rd_cmd_en(rcmd_en), .rd_cmd_addr(rcmd_addr),
        .rd_cmd_len(rcmd_len), .read_data(read_data_i), .rd_cmd_ready(rcmd_ready),
        .rd_cmd_done(rcmd_done), .read_en(read_en_o),
`endif
        .grant_id(gid)
    );

    int nvec = 0, nbad = 0;
    int ndone[NCH];
    int nhs = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 command offered, 2 data moving, 3 one-cycle done.
    int ph = 0, mg = 0, mptr = 0;
    bit mzero = 1'b0, chk_on = 1'b0;
    logic [AW-1:0] maddr;
    logic [LW-1:0] mlen;

    always @(posedge clk) begin
        logic [SL-1:0] rq;
        int w;
        bit rdy, dn;
        rq = SL'(req);
        rdy = cmd_ready;
        dn = cmd_done;
`ifdef DDR_ARBIT_RD_EN
        rq[NCH] = rd_req_i;
        if (mg == NCH) begin
            rdy = rcmd_ready;
            dn = rcmd_done;
        end
`endif
        if (rst) begin
            ph = 0;
            mptr = 0;
            chk_on = 1'b1;
        end else if (ph == 0) begin
            w = -1;
            for (int k = SL - 1; k >= 0; k--)
                if (rq[(mptr + k) % SL]) w = (mptr + k) % SL;
            if (w >= 0) begin
                mg = w;
                if (w < NCH) begin
                    maddr = addr[w*AW +: AW];
                    mlen = len[w*LW +: LW];
                end
`ifdef DDR_ARBIT_RD_EN
                else begin
                    maddr = rd_addr_i;
                    mlen = rd_len_i;
                end
`endif
                mzero = (mlen == 0);
                ph = mzero ? 3 : 1;
                if (mzero) mptr = (w + 1) % SL;
            end
        end else if (ph == 1) begin
            if (rdy) ph = 2;
        end else if (ph == 2) begin
            if (dn) begin
                ph = 3;
                mptr = (mg + 1) % SL;
            end
        end else begin
            ph = 0;
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] oh;
        bit wr;
        wr = (ph != 0) && (mg < NCH);
        oh = wr ? NCH'(1) << mg : '0;
        if (chk_on) begin
            chk("grant_id", gid, (ph == 0) ? 4'hF : 4'(mg));
            chk("wr_cmd_en", cmd_en, ph == 1 && wr);
            chk("wr_cmd_addr", cmd_addr, (ph == 1 && wr) ? maddr : '0);
            chk("wr_cmd_len", cmd_len, (ph == 1 && wr) ? 32'(mlen) : '0);
            chk("m_ddr_wrdy", wrdy, (ph == 1 && cmd_ready) ? oh : '0);
            chk("m_ddr_wdata_req", wdreq, (ph == 2 && data_re) ? oh : '0);
            chk("wr_ctrl_data", ctrl_data, (ph == 2 && wr) ? data[mg*DW +: DW] : '0);
            chk("m_ddr_wdone", wdone, ((ph == 2 && cmd_done) || (ph == 3 && mzero)) ? oh : '0);
`ifdef DDR_ARBIT_RD_EN
            begin
                bit rr;
                rr = (ph != 0) && (mg == NCH);
                chk("rd_cmd_en", rcmd_en, ph == 1 && rr);
                chk("rd_cmd_addr", rcmd_addr, (ph == 1 && rr) ? maddr : '0);
                chk("m1_rd_ddr_rrdy", rrdy_o, ph == 1 && rr && rcmd_ready);
                chk("m1_rd_ddr_rdata_en", rdata_en_o, ph == 2 && rr);
                chk("read_en", read_en_o, ph == 2 && rr);
                chk("m1_rd_data", rd_data_o, (ph == 2 && rr) ? read_data_i : '0);
                chk("m1_rd_ddr_rdone", rdone_o, rr && ((ph == 2 && rcmd_done) || (ph == 3 && mzero)));
            end
`endif
            for (int c = 0; c < NCH; c++) if (wdone[c]) ndone[c]++;
            if (cmd_en && cmd_ready) nhs++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hs(input int g, input bit r, input bit d);
        if (g == NCH) begin
`ifdef DDR_ARBIT_RD_EN
            rcmd_ready = r;
            rcmd_done = d;
`endif
        end else begin
            cmd_ready = r;
            cmd_done = d;
        end
    endtask

    task automatic burst(input int rdly, input int ddly, input bit drop,
                         output int g, output logic [AW-1:0] a);
        int t = 0;
        g = -1;
        a = '0;
        while (!any_en && t < 50) begin
            tick();
            t++;
        end
        if (!any_en) begin
            nvec++;
            nbad++;
            $display("FAIL burst_wait: no command enable after %0d cycles, expected one", t);
            return;
        end
        g = int'(gid);
        a = cmd_addr;
        if (drop) req = '0;
        repeat (rdly) tick();
        set_hs(g, 1'b1, 1'b0);
        tick();
        set_hs(g, 1'b0, 1'b0);
        data_re = 1'b1;
        repeat (ddly) tick();
`ifdef DDR_ARBIT_RD_EN
        if (g == NCH) chk("rd_data_lit", rd_data_o, {32{8'hA5}});
`endif
        data_re = 1'b0;
        set_hs(g, 1'b0, 1'b1);
        tick();
        set_hs(g, 1'b0, 1'b0);
    endtask

    int fair_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int g, t, d0, base;
        logic [AW-1:0] a;
        for (int c = 0; c < NCH; c++) begin
            ndone[c] = 0;
            addr[c*AW +: AW] = 28'h0A00010 + 28'(c << 12);
            len[c*LW +: LW] = 32'd16;
            data[c*DW +: DW] = {8{32'hD0D00000 + 32'(c)}};
        end
        repeat (2) tick();
        chk("rst_gid", gid, 4'hF);
        chk("rst_en", cmd_en, 1'b0);
        chk("rst_wdone", wdone, 4'b0000);
        rst = 1'b0;

        req = 4'b0100;
        burst(3, 20, 1'b1, g, a);
        chk("single_grant", g, 2);
        chk("single_addr", a, 28'h0A02010);
        repeat (2) tick();
        chk("single_idle_gid", gid, 4'hF);
        chk("single_wdone2", ndone[2], 1);
        chk("single_handshakes", nhs, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            burst(1, 2, 1'b0, g, a);
            chk("fair_order", g, fair_exp[i]);
        end
        req = '0;
        repeat (2) tick();

        req = 4'b0100;
        burst(0, 1, 1'b1, g, a);
        chk("wrap_pre", g, 2);
        req = 4'b0011;
        burst(1, 1, 1'b0, g, a);
        chk("wrap_first", g, 0);
        burst(1, 1, 1'b1, g, a);
        chk("wrap_second", g, 1);
        repeat (2) tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        len[1*LW +: LW] = '0;
        base = nhs;
        req = 4'b0110;
        tick();
        chk("zero_gid", gid, 4'd1);
        chk("zero_wdone", wdone, 4'b0010);
        chk("zero_no_en", cmd_en, 1'b0);
        tick();
        chk("zero_pulse_once", wdone, 4'b0000);
        burst(1, 2, 1'b1, g, a);
        chk("zero_next", g, 2);
        chk("zero_one_hs", nhs, base + 1);
        len[1*LW +: LW] = 32'd16;
        repeat (2) tick();

        req = 4'b0100;
        t = 0;
        while (!cmd_en && t < 50) begin
            tick();
            t++;
        end
        chk("mid_cmd_seen", cmd_en, 1'b1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        data_re = 1'b1;
        repeat (4) tick();
        d0 = ndone[2];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        chk("mid_rst_gid", gid, 4'hF);
        chk("mid_rst_wdreq", wdreq, 4'b0000);
        chk("mid_rst_data", ctrl_data, '0);
        chk("mid_rst_wdone", wdone, 4'b0000);
        data_re = 1'b0;
        burst(1, 2, 1'b1, g, a);
        chk("mid_next_grant", g, 0);
        chk("mid_no_done", ndone[2], d0);
        repeat (2) tick();

`ifdef DDR_ARBIT_RD_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        rd_req_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            burst(1, 2, 1'b0, g, a);
            chk("rd_order", g, i);
        end
        req = '0;
        rd_req_i = 1'b0;
        repeat (2) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule

// File: doc/ddr_arbit_nch.md
DDR_ARBIT_NCH -- requirements
Module: ddr_arbit_nch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of write channels, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 28: DDR command address width.
REQ-003 SHALL have parameter LEN_W, default 32: burst length width per channel.
REQ-004 SHALL have parameter DATA_W, default 256: write/read data width.
REQ-005 SHALL have the following ports, one per line as name, direction, width, meaning:
- ddr_clk  in  1  sole clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- m_wr_req  in  NUM_CH  per-channel write request, level.
- m_wr_addr  in  NUM_CH*ADDR_W  packed write addresses, channel 0 in the LSBs.
- m_wr_len  in  NUM_CH*LEN_W  packed burst lengths.
- m_wr_data  in  NUM_CH*DATA_W  packed write data.
- m_ddr_wrdy  out  NUM_CH  command-accepted pulse to the granted channel.
- m_ddr_wdata_req  out  NUM_CH  data-pop strobe to the granted channel.
- m_ddr_wdone  out  NUM_CH  one-cycle burst-done pulse.
- wr_cmd_en / wr_cmd_addr / wr_cmd_len  out  1/ADDR_W/32  write command to the controller.
- wr_cmd_ready / wr_cmd_done / wr_data_re  in  1  controller handshakes.
- wr_ctrl_data  out  DATA_W  write data to the controller.
- grant_id  out  4  index of the current owner, 4'hF when idle.

Function
REQ-006 SHALL implement states IDLE, WR_CMD, WR_DATA, DONE, plus RD_CMD and RD_DATA under REQ-021.
REQ-007 In IDLE, when any request is high, SHALL select in one cycle the first requesting index at or after rr_ptr, wrapping modulo the slot count.
REQ-008 On selection, SHALL latch the grant, address and length, then enter WR_CMD on the next cycle.
REQ-009 Requests dropping after grant SHALL NOT abort the burst.
REQ-010 In WR_CMD, SHALL hold wr_cmd_en=1 with the latched address and length until wr_cmd_ready=1 is sampled.
REQ-011 In the wr_cmd_ready cycle, m_ddr_wrdy[g] SHALL be 1, and the next state SHALL be WR_DATA.
REQ-012 In WR_DATA, wr_ctrl_data SHALL be m_wr_data slice g (combinational) and m_ddr_wdata_req[g] SHALL equal wr_data_re; all other bits SHALL be 0.
REQ-013 On wr_cmd_done in WR_DATA, SHALL pulse m_ddr_wdone[g] for one cycle, set rr_ptr=(g+1) mod slots, and enter DONE.
REQ-014 DONE SHALL last one cycle, then return to IDLE; arbitration latency from request to wr_cmd_en SHALL be 2 cycles.
REQ-015 SHALL ignore wr_cmd_done outside WR_DATA, and wr_data_re outside WR_DATA.
REQ-016 A granted request with length 0 SHALL issue no command, pulse m_ddr_wdone[g] in the cycle after grant, and advance rr_ptr.
REQ-017 The wr_cmd_len output SHALL zero-extend LEN_W to 32 bits.
REQ-018 All outputs not owned by the grant SHALL be 0; wr_ctrl_data SHALL be 0 outside WR_DATA.

Reset
REQ-019 On rst=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0 and grant_id=4'hF, and drive all outputs to 0.
REQ-020 Reset mid-burst SHALL abandon the burst without emitting any done pulse.

Configuration
REQ-021 With macro DDR_ARBIT_RD_EN defined, SHALL add the ports m1_rd_req, m1_rd_addr, m1_rd_len, m1_rd_data, m1_rd_ddr_rrdy, m1_rd_ddr_rdata_en, m1_rd_ddr_rdone, rd_cmd_en, rd_cmd_addr, rd_cmd_len, read_data, rd_cmd_ready, rd_cmd_done and read_en.
- The read requester SHALL be slot NUM_CH in the rotation.
- RD_CMD and RD_DATA SHALL mirror WR_CMD and WR_DATA.
- read_data SHALL pass to m1_rd_data.
- read_en SHALL equal m1_rd_ddr_rdata_en, which is high in RD_DATA.
REQ-022 Without DDR_ARBIT_RD_EN, the read ports SHALL be absent and the slot count SHALL be NUM_CH.

Structure
REQ-023 Package ddr_arbit_pkg SHALL hold the state encoding, the IDLE_ID constant 4'hF and a max-channel constant of 8.
REQ-024 The round-robin priority selector SHALL be sub-module rr_pick (inputs: request vector and pointer; outputs: grant index and valid), purely combinational; the FSM SHALL stay in ddr_arbit_nch.

Verification
REQ-025 Single request: m_wr_req=4'b0100, length 16, ready after 3 cycles, done 20 cycles later -> one wr_cmd_en handshake with the ch2 address, exactly one m_ddr_wdone[2] pulse, and grant_id back to 4'hF.
REQ-026 Fairness: all four requests held high, 8 bursts -> grant order 0,1,2,3,0,1,2,3.
REQ-027 Pointer wrap: rr_ptr=3 with requests 4'b0011 -> ch0 granted, then ch1.
REQ-028 Zero length: ch1 length 0 -> no wr_cmd_en, m_ddr_wdone[1] one cycle after grant, and ch2 served next.
REQ-029 Reset at cycle 5 of WR_DATA -> all outputs 0 next cycle, no wdone pulse, and the next grant is ch0.
REQ-030 With DDR_ARBIT_RD_EN, write requests 4'b1111 plus m1_rd_req -> order 0,1,2,3,read, with read_data=256'hA5..A5 appearing on m1_rd_data.
